// File: rtl/gato_pkg.sv
// Shared definitions for the move link receiver: FSM states, frame type
// codes, board limits and the even-parity helper.
// Optional feature: MOVE_LINK_PARITY_EN enables the even-parity bit.
package gato_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DECODE
  } rx_state_e;

  localparam logic [1:0] TYPE_MOVE = 2'b00;
  localparam logic [1:0] TYPE_CTRL = 2'b01;

  localparam logic [3:0] MAX_CELL = 4'd8;

  // Even parity: the transmitted parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period counter for the UART receiver.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   restart_i    - zero the counter (start of a new timing window)
//   half_tick_c  - combinational, high when half a bit period has elapsed
//   full_tick_c  - combinational, high when a full bit period has elapsed
// The counter wraps on every full tick, so consecutive data bits need no
// restart.
module rx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic half_tick_c,
  output logic full_tick_c
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned FULL_T = (CLKS_PER_BIT > 1) ? CLKS_PER_BIT : 2;
  localparam int unsigned HALF_T = FULL_T / 2;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign half_tick_c = (cnt_q == CNT_W'(HALF_T - 1));
  assign full_tick_c = (cnt_q == CNT_W'(FULL_T - 1));

  // Next count: restart wins, otherwise wrap at the full period.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart_i || full_tick_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/move_link_rx.sv
// Serial receiver for tic-tac-toe moves and control codes from the Arduino.
// Ports:
//   clk, Reset  - clock, async active-low reset
//   rx          - serial line, idle high, asynchronous
//   posicion    - cell index (0-8) of the held move
//   move_valid  - a move is held and not yet acknowledged
//   move_ack    - consumer takes the held move
//   interrupt   - one-cycle control code from a control frame
//   frame_err, overrun, range_err - sticky error flags, cleared by Reset
// Frame byte: [7:6] type, [5:4] ignored, [3:0] payload.
// Optional feature: define MOVE_LINK_PARITY_EN for 8E1 framing (default 8N1).
module move_link_rx
  import gato_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       rx,
  output logic [3:0] posicion,
  output logic       move_valid,
  input  logic       move_ack,
  output logic [3:0] interrupt,
  output logic       frame_err,
  output logic       overrun,
  output logic       range_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

  rx_state_e  state_q, state_d;
  logic       rx_s1_q, rx_s2_q, rx_prev_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] posicion_q, posicion_d;
  logic       move_valid_q, move_valid_d;
  logic [3:0] interrupt_q, interrupt_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;
  logic       range_err_q, range_err_d;

  logic       fall_c, restart_c, half_tick_c, full_tick_c;

  assign fall_c = rx_prev_q & ~rx_s2_q;

  rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .rst_n      (Reset),
    .restart_i  (restart_c),
    .half_tick_c(half_tick_c),
    .full_tick_c(full_tick_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    posicion_d   = posicion_q;
    move_valid_d = move_valid_q;
    interrupt_d  = '0;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    range_err_d  = range_err_q;
    restart_c    = 1'b0;

    if (move_ack && move_valid_q) begin
      move_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (fall_c) begin
          restart_c = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (half_tick_c) begin
          // Line back high at mid-start: treat as a glitch.
          if (rx_s2_q) begin
            state_d = IDLE;
          end else begin
            restart_c = 1'b1;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (full_tick_c) begin
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef MOVE_LINK_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef MOVE_LINK_PARITY_EN
      PARITY: begin
        if (full_tick_c) begin
          if (rx_s2_q != even_parity(shift_q)) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (full_tick_c) begin
          if (!rx_s2_q) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        state_d = IDLE;
        if (shift_q[7:6] == TYPE_MOVE) begin
          if (shift_q[3:0] > MAX_CELL) begin
            range_err_d = 1'b1;
          end else if (move_valid_q && !move_ack) begin
            overrun_d = 1'b1;
          end else begin
            // A same-cycle ack frees the slot, so the new move loads cleanly.
            posicion_d   = shift_q[3:0];
            move_valid_d = 1'b1;
          end
        end else if (shift_q[7:6] == TYPE_CTRL) begin
          interrupt_d = shift_q[3:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      posicion_q   <= '0;
      move_valid_q <= 1'b0;
      interrupt_q  <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_s1_q      <= rx;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      posicion_q   <= posicion_d;
      move_valid_q <= move_valid_d;
      interrupt_q  <= interrupt_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      range_err_q  <= range_err_d;
    end
  end

  assign posicion   = posicion_q;
  assign move_valid = move_valid_q;
  assign interrupt  = interrupt_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign range_err  = range_err_q;

endmodule
